// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch sequencing controller.
// Covers the FSM state enum, the BCD digit bundle and the default tick rate.
package stopwatch_pkg;

  localparam int TICK_HZ_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    PAUSE
  } sw_state_t;

  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] cseg1;
    logic [3:0] cseg0;
  } digits_t;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge detector.
// Used by stopwatch_ctrl only when STOPWATCH_BTN_SYNC_EN is defined.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  // sr_q[0], sr_q[1] form the synchronizer; sr_q[2] holds the previous synchronized level.
  logic [2:0] sr_q, sr_d;
  logic       pulse_q, pulse_d;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    sr_d    = {sr_q[1:0], btn_i};
    pulse_d = sr_q[1] & ~sr_q[2];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: start/stop, lap snapshot and clear for the BCD counter.
// Define STOPWATCH_BTN_SYNC_EN to accept raw level buttons (synchronized and edge-detected).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = TICK_HZ_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  input  logic [31:0] digits_i,
  output logic        carry_o,
  output logic        cnt_clr_o,
  output logic [31:0] disp_o,
  output logic        running_o,
  output logic        lap_o
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic start_stop, lap, clear;

`ifdef STOPWATCH_BTN_SYNC_EN
  btn_edge u_ss_edge  (.clk(clk), .rst(rst), .btn_i(start_stop_i), .pulse_o(start_stop));
  btn_edge u_lap_edge (.clk(clk), .rst(rst), .btn_i(lap_i),        .pulse_o(lap));
  btn_edge u_clr_edge (.clk(clk), .rst(rst), .btn_i(clear_i),      .pulse_o(clear));
`else
  assign start_stop = start_stop_i;
  assign lap        = lap_i;
  assign clear      = clear_i;
`endif

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  digits_t       snap_q, snap_d;
  logic          carry_q, carry_d;
  logic          clr_q, clr_d;
  logic          running_q, running_d;
  logic          lap_q, lap_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    snap_d  = snap_q;
    carry_d = 1'b0;
    clr_d   = 1'b0;

    // The prescaler advances on the current state, so a tick due on a stop edge still fires.
    if (state_q == RUN || state_q == LAP) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        carry_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (state_q == IDLE) begin
      presc_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (clear)           clr_d   = 1'b1;
        else if (start_stop) state_d = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap) begin
          state_d = LAP;
          snap_d  = digits_t'(digits_i);
        end
      end
      LAP: begin
        if (start_stop) state_d = PAUSE;
        else if (lap)   state_d = RUN;
      end
      PAUSE: begin
        if (clear) begin
          clr_d   = 1'b1;
          presc_d = '0;
          state_d = IDLE;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN) || (state_d == LAP);
    lap_d     = (state_d == LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      snap_q    <= '0;
      carry_q   <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      snap_q    <= snap_d;
      carry_q   <= carry_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      lap_q     <= lap_d;
    end
  end

  assign carry_o   = carry_q;
  assign cnt_clr_o = clr_q;
  assign running_o = running_q;
  assign lap_o     = lap_q;
  assign disp_o    = (state_q == LAP) ? 32'(snap_q) : digits_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (default build, DIV = 10).
// Directed scenarios plus a randomized run against a behavioural model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop_i = 1'b0;
  logic        lap_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] digits_i = '0;
  logic        carry_o, cnt_clr_o, running_o, lap_o;
  logic [31:0] disp_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode plus total running cycles since the last clear.
  sw_state_t   m_state = IDLE;
  int unsigned m_run_cycles = 0;
  logic [31:0] m_snap = '0;
  bit          m_carry = 0;
  bit          m_clr = 0;

  stopwatch_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .start_stop_i(start_stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .digits_i(digits_i), .carry_o(carry_o),
    .cnt_clr_o(cnt_clr_o), .disp_o(disp_o), .running_o(running_o), .lap_o(lap_o)
  );

  always #5 clk = ~clk;

  task automatic reset_model();
    m_state = IDLE;
    m_run_cycles = 0;
    m_snap = '0;
    m_carry = 0;
    m_clr = 0;
  endtask

  // One clock with the given commands; the model advances on the same edge.
  task automatic step(input bit ss, input bit lp, input bit cl);
    start_stop_i = ss;
    lap_i = lp;
    clear_i = cl;
    @(posedge clk);
    m_carry = 0;
    m_clr = 0;
    if (m_state == RUN || m_state == LAP) begin
      m_run_cycles++;
      m_carry = (m_run_cycles % DIV) == 0;
    end
    case (m_state)
      IDLE:  if (cl) m_clr = 1; else if (ss) m_state = RUN;
      RUN:   if (ss) m_state = PAUSE; else if (lp) begin m_state = LAP; m_snap = digits_i; end
      LAP:   if (ss) m_state = PAUSE; else if (lp) m_state = RUN;
      PAUSE: if (cl) begin m_clr = 1; m_run_cycles = 0; m_state = IDLE; end
             else if (ss) m_state = RUN;
      default: ;
    endcase
    #1;
    start_stop_i = 0;
    lap_i = 0;
    clear_i = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    digits_i = 32'h1357_2468;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_model();
    n_checks++;
    if ({carry_o, cnt_clr_o, running_o, lap_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs carry/clr/run/lap=%b expected 0000",
               {carry_o, cnt_clr_o, running_o, lap_o});
    end
    n_checks++;
    if (disp_o !== 32'h1357_2468) begin
      n_fail++;
      $display("FAIL reset_disp disp_o=%h expected 13572468", disp_o);
    end
    rst = 0;
  endtask

  task automatic test_start_ticks();
    step(1, 0, 0);
    n_checks++;
    if (running_o !== 1'b1 || lap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_running running_o=%b lap_o=%b expected 1 0", running_o, lap_o);
    end
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0);
      n_checks++;
      if (carry_o !== ((k % DIV) == 0)) begin
        n_fail++;
        $display("FAIL start_tick cycle=%0d carry_o=%b expected %b", k, carry_o, (k % DIV) == 0);
      end
    end
  endtask

  task automatic test_pause_phase();
    int ticks = 0;
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if (running_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_running running_o=%b expected 0", running_o);
    end
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0);
      if (carry_o === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 0) begin
      n_fail++;
      $display("FAIL pause_no_tick ticks=%0d expected 0", ticks);
    end
    step(1, 0, 0);
    while (!seen && n < 20) begin
      step(0, 0, 0);
      n++;
      if (carry_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || n != 6) begin
      n_fail++;
      $display("FAIL resume_phase first tick after %0d cycles (seen=%0d) expected 6", n, seen);
    end
  endtask

  task automatic test_lap_freeze();
    int ticks = 0;
    int bad_disp = 0;
    digits_i = 32'h0000_1234;
    step(0, 1, 0);
    n_checks++;
    if (lap_o !== 1'b1 || running_o !== 1'b1 || disp_o !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL lap_enter lap_o=%b running_o=%b disp_o=%h expected 1 1 00001234",
               lap_o, running_o, disp_o);
    end
    digits_i = 32'h0000_1299;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0);
      if (disp_o !== 32'h0000_1234) bad_disp++;
      if (carry_o === 1'b1) ticks++;
    end
    n_checks++;
    if (bad_disp != 0) begin
      n_fail++;
      $display("FAIL lap_hold disp_o=%h in %0d cycles expected 00001234", disp_o, bad_disp);
    end
    n_checks++;
    if (ticks != 1) begin
      n_fail++;
      $display("FAIL lap_ticks ticks=%0d expected 1", ticks);
    end
    step(0, 1, 0);
    n_checks++;
    if (lap_o !== 1'b0 || running_o !== 1'b1 || disp_o !== 32'h0000_1299) begin
      n_fail++;
      $display("FAIL lap_release lap_o=%b running_o=%b disp_o=%h expected 0 1 00001299",
               lap_o, running_o, disp_o);
    end
  endtask

  task automatic test_clear_rules();
    int n = 0;
    bit seen = 0;
    step(0, 0, 1);
    n_checks++;
    if (cnt_clr_o !== 1'b0 || running_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_in_run cnt_clr_o=%b running_o=%b expected 0 1", cnt_clr_o, running_o);
    end
    step(1, 0, 0);
    step(0, 0, 1);
    n_checks++;
    if (cnt_clr_o !== 1'b1 || running_o !== 1'b0 || lap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_pause cnt_clr_o=%b running_o=%b lap_o=%b expected 1 0 0",
               cnt_clr_o, running_o, lap_o);
    end
    step(0, 0, 0);
    n_checks++;
    if (cnt_clr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_width cnt_clr_o=%b expected 0", cnt_clr_o);
    end
    step(1, 0, 0);
    while (!seen && n < 30) begin
      step(0, 0, 0);
      n++;
      if (carry_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || n != DIV) begin
      n_fail++;
      $display("FAIL clear_prescaler first tick after %0d cycles (seen=%0d) expected 10", n, seen);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    bit seen = 0;
    step(1, 0, 0);
    step(1, 0, 1);
    n_checks++;
    if (cnt_clr_o !== 1'b1 || running_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins cnt_clr_o=%b running_o=%b expected 1 0", cnt_clr_o, running_o);
    end
    step(1, 0, 0);
    while (!seen && n < 30) begin
      step(0, 0, 0);
      n++;
      if (carry_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || n != DIV) begin
      n_fail++;
      $display("FAIL clear_wins_restart first tick after %0d cycles (seen=%0d) expected 10", n, seen);
    end
    digits_i = 32'h0000_5555;
    step(1, 1, 0);
    n_checks++;
    if (running_o !== 1'b0 || lap_o !== 1'b0 || disp_o !== 32'h0000_5555) begin
      n_fail++;
      $display("FAIL ss_over_lap running_o=%b lap_o=%b disp_o=%h expected 0 0 00005555",
               running_o, lap_o, disp_o);
    end
    step(0, 1, 0);
    n_checks++;
    if (lap_o !== 1'b0 || running_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_in_pause lap_o=%b running_o=%b expected 0 0", lap_o, running_o);
    end
  endtask

  task automatic test_mid_run_reset();
    step(1, 0, 0);
    digits_i = 32'h0000_2222;
    step(0, 1, 0);
    n_checks++;
    if (lap_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_lap lap_o=%b expected 1", lap_o);
    end
    digits_i = 32'h0000_3333;
    rst = 1;
    @(posedge clk);
    #1;
    reset_model();
    n_checks++;
    if ({carry_o, cnt_clr_o, running_o, lap_o} !== 4'b0000 || disp_o !== 32'h0000_3333) begin
      n_fail++;
      $display("FAIL mid_run_reset carry/clr/run/lap=%b disp_o=%h expected 0000 00003333",
               {carry_o, cnt_clr_o, running_o, lap_o}, disp_o);
    end
    rst = 0;
    step(0, 0, 0);
    n_checks++;
    if (cnt_clr_o !== 1'b0 || running_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset cnt_clr_o=%b running_o=%b expected 0 0", cnt_clr_o, running_o);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    logic [31:0] exp_disp;
    for (int i = 0; i < 600; i++) begin
      digits_i = $urandom;
      r = $urandom_range(0, 11);
      step(r == 0, r == 1, r == 2);
      exp_disp = (m_state == LAP) ? m_snap : digits_i;
      n_checks++;
      if (carry_o !== m_carry || cnt_clr_o !== m_clr) begin
        n_fail++;
        $display("FAIL rand_pulses i=%0d carry/clr=%b%b expected %b%b",
                 i, carry_o, cnt_clr_o, m_carry, m_clr);
      end
      n_checks++;
      if (running_o !== (m_state == RUN || m_state == LAP) || lap_o !== (m_state == LAP)) begin
        n_fail++;
        $display("FAIL rand_state i=%0d running/lap=%b%b expected %b%b", i, running_o, lap_o,
                 (m_state == RUN || m_state == LAP), (m_state == LAP));
      end
      n_checks++;
      if (disp_o !== exp_disp) begin
        n_fail++;
        $display("FAIL rand_disp i=%0d disp_o=%h expected %h", i, disp_o, exp_disp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_pause_phase();
    test_lap_freeze();
    test_clear_rules();
    test_simultaneous();
    test_mid_run_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
